// File: rtl/compute_issue_decode.sv
// Decode/issue stage for the compute datapath: handshaked instruction intake, decode,
// register scoreboard with RAW/WAW stalls. Optional PADDSB opcode via COMPUTE_DEC_PADDSB_EN.
module compute_issue_decode #(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_alu_op,
  output logic            out_sub,
  output logic            out_pad,
  output logic [1:0]      out_shmode,
  output logic [AW-1:0]   out_rd,
  output logic [AW-1:0]   out_rs,
  output logic [AW-1:0]   out_rt,
  output logic [3:0]      out_imm,
  output logic [2:0]      out_flag_wr,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  output logic            ill_op,
  output logic [NREG-1:0] busy
);

  logic [3:0]      opc;
  logic [AW-1:0]   dec_rd;
  logic [AW-1:0]   dec_rs;
  logic [AW-1:0]   dec_rt;
  logic [2:0]      dec_alu;
  logic            dec_sub;
  logic [1:0]      dec_shmode;
  logic [3:0]      dec_imm;
  logic [2:0]      dec_flag;
  logic            uses_rt;
  logic            illegal;
`ifdef COMPUTE_DEC_PADDSB_EN
  logic            dec_pad;
  logic            pad_q;
`endif

  logic            out_valid_q, out_valid_d;
  logic [2:0]      alu_op_q;
  logic            sub_q;
  logic [1:0]      shmode_q;
  logic [AW-1:0]   rd_q, rs_q, rt_q;
  logic [3:0]      imm_q;
  logic [2:0]      flag_q;
  logic            ill_op_q;
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_vec, clr_vec;

  logic            slot_free;
  logic            hazard;
  logic            accept;
  logic            issue;

  assign opc    = in_instr[15:12];
  assign dec_rd = in_instr[8 +: AW];
  assign dec_rs = in_instr[4 +: AW];

  always_comb begin
    dec_alu    = opc[2:0];
    dec_sub    = 1'b0;
    dec_shmode = 2'd0;
    dec_rt     = in_instr[0 +: AW];
    dec_imm    = 4'd0;
    dec_flag   = 3'b001;
    uses_rt    = 1'b1;
    illegal    = opc[3];
`ifdef COMPUTE_DEC_PADDSB_EN
    dec_pad    = 1'b0;
`endif
    case (opc)
      4'd0: dec_flag = 3'b111;
      4'd1: begin
        dec_sub  = 1'b1;
        dec_flag = 3'b111;
      end
      4'd3: dec_flag = 3'b000;
      // Shifts: low opcode bits map directly onto the shifter mode; rt field is the amount.
      4'd4, 4'd5, 4'd6: begin
        dec_shmode = opc[1:0];
        dec_rt     = '0;
        dec_imm    = in_instr[3:0];
        uses_rt    = 1'b0;
      end
      4'd7: begin
`ifdef COMPUTE_DEC_PADDSB_EN
        dec_pad  = 1'b1;
        dec_flag = 3'b111;
`else
        illegal  = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Illegal words bypass the hazard check: they are dropped, so they never touch registers.
  assign slot_free = !out_valid_q | out_ready;
  assign hazard    = busy_q[dec_rs] | (uses_rt & busy_q[dec_rt]) | busy_q[dec_rd];
  assign in_ready  = slot_free & (illegal | !hazard);
  assign accept    = in_valid & in_ready;
  assign issue     = accept & !illegal;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign set_vec[gi] = 1'b0;
        assign clr_vec[gi] = 1'b0;
        assign busy_d[gi]  = 1'b0;
      end else begin : g_reg
        assign set_vec[gi] = issue & (dec_rd == AW'(gi));
        assign clr_vec[gi] = wb_valid & (wb_rd == AW'(gi));
        // Set wins over a same-cycle writeback of the same register.
        assign busy_d[gi]  = set_vec[gi] | (busy_q[gi] & !clr_vec[gi]);
      end
    end
  endgenerate

  always_comb begin
    out_valid_d = out_valid_q;
    if (issue) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= '0;
      sub_q       <= 1'b0;
      shmode_q    <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      flag_q      <= '0;
      ill_op_q    <= 1'b0;
      busy_q      <= '0;
`ifdef COMPUTE_DEC_PADDSB_EN
      pad_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      ill_op_q    <= accept & illegal;
      busy_q      <= busy_d;
      if (issue) begin
        alu_op_q <= dec_alu;
        sub_q    <= dec_sub;
        shmode_q <= dec_shmode;
        rd_q     <= dec_rd;
        rs_q     <= dec_rs;
        rt_q     <= dec_rt;
        imm_q    <= dec_imm;
        flag_q   <= dec_flag;
`ifdef COMPUTE_DEC_PADDSB_EN
        pad_q    <= dec_pad;
`endif
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_alu_op  = alu_op_q;
  assign out_sub     = sub_q;
  assign out_shmode  = shmode_q;
  assign out_rd      = rd_q;
  assign out_rs      = rs_q;
  assign out_rt      = rt_q;
  assign out_imm     = imm_q;
  assign out_flag_wr = flag_q;
  assign ill_op      = ill_op_q;
  assign busy        = busy_q;
`ifdef COMPUTE_DEC_PADDSB_EN
  assign out_pad     = pad_q;
`else
  assign out_pad     = 1'b0;
`endif

endmodule

// File: tb/tb_compute_issue_decode.sv
// Self-checking bench for compute_issue_decode: directed scenarios then randomized traffic,
// all compared against a per-cycle architectural model (honours COMPUTE_DEC_PADDSB_EN).
module tb_compute_issue_decode;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_instr;
  logic [2:0]  out_alu_op, out_flag_wr;
  logic        out_sub, out_pad, ill_op, wb_valid;
  logic [1:0]  out_shmode;
  logic [3:0]  out_rd, out_rs, out_rt, out_imm, wb_rd;
  logic [15:0] busy;

  always #5 clk = ~clk;

  compute_issue_decode dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op), .out_sub(out_sub),
    .out_pad(out_pad), .out_shmode(out_shmode), .out_rd(out_rd), .out_rs(out_rs),
    .out_rt(out_rt), .out_imm(out_imm), .out_flag_wr(out_flag_wr), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .ill_op(ill_op), .busy(busy)
  );

  logic [25:0] dut_bundle;
  assign dut_bundle = {out_alu_op, out_sub, out_pad, out_shmode, out_rd, out_rs, out_rt,
                       out_imm, out_flag_wr};

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model state
  bit          m_valid;
  bit          m_ill;
  bit [15:0]   m_busy;
  bit [25:0]   m_bundle;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_shift(input logic [3:0] op);
    return (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
  endfunction

  function automatic bit is_illegal(input logic [15:0] ins);
`ifdef COMPUTE_DEC_PADDSB_EN
    return ins[15];
`else
    return ins[15] || (ins[15:12] == 4'd7);
`endif
  endfunction

  // Expected bundle, from the opcode table: ADD SUB XOR RED SLL SRA ROR PADDSB
  function automatic bit [25:0] ref_bundle(input logic [15:0] ins);
    bit [3:0] op;
    bit [2:0] alu, flag;
    bit       sub, pad;
    bit [1:0] shm;
    bit [3:0] rt, imm;
    op   = ins[15:12];
    alu  = op[2:0];
    sub  = (op == 4'd1);
    pad  = (op == 4'd7);
    shm  = is_shift(op) ? 2'(op - 4'd4) : 2'd0;
    rt   = is_shift(op) ? 4'd0 : ins[3:0];
    imm  = is_shift(op) ? ins[3:0] : 4'd0;
    if (op == 4'd3)                               flag = 3'b000;
    else if (op == 4'd0 || op == 4'd1 || op == 4'd7) flag = 3'b111;
    else                                          flag = 3'b001;
    return {alu, sub, pad, shm, ins[11:8], ins[7:4], rt, imm, flag};
  endfunction

  function automatic bit ref_ready(input logic [15:0] ins, input logic ordy);
    bit free, haz;
    free = !m_valid || ordy;
    haz  = m_busy[ins[7:4]] || m_busy[ins[11:8]] ||
           (!is_shift(ins[15:12]) && m_busy[ins[3:0]]);
    return free && (is_illegal(ins) || !haz);
  endfunction

  task automatic step(input logic r, input logic iv, input logic [15:0] ins,
                      input logic ordy, input logic wbv, input logic [3:0] wbrd);
    bit exp_rdy, acc, ill;
    bit [15:0] setv, clrv;
    rst = r; in_valid = iv; in_instr = ins; out_ready = ordy; wb_valid = wbv; wb_rd = wbrd;
    @(negedge clk);
    exp_rdy = ref_ready(ins, ordy);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("ill_op", {31'd0, ill_op}, {31'd0, m_ill});
    check("busy", {16'd0, busy}, {16'd0, m_busy});
    if (m_valid) check("bundle", {6'd0, dut_bundle}, {6'd0, m_bundle});
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_ill = 0; m_busy = '0; m_bundle = '0;
    end else begin
      acc   = iv && exp_rdy;
      ill   = acc && is_illegal(ins);
      m_ill = ill;
      setv  = (acc && !ill) ? (16'd1 << ins[11:8]) : 16'd0;
      clrv  = wbv ? (16'd1 << wbrd) : 16'd0;
      m_busy = ((m_busy & ~clrv) | setv) & 16'hFFFE;
      if (acc && !ill) begin
        m_valid  = 1;
        m_bundle = ref_bundle(ins);
      end else if (ordy) begin
        m_valid = 0;
      end
      if (acc) $display("accept instr=%04h illegal=%0d busy_next=%04h", ins, ill, m_busy);
    end
    #1;
  endtask

  initial begin
    bit [3:0] op;
    rst = 1; in_valid = 0; in_instr = '0; out_ready = 0; wb_valid = 0; wb_rd = '0;
    m_valid = 0; m_ill = 0; m_busy = '0; m_bundle = '0;
    @(posedge clk); #1;
    step(1, 0, 16'h0, 0, 0, 4'd0);
    check("rst_bundle", {6'd0, dut_bundle}, 32'd0);

    // 1: ADD r3,r1,r2
    step(0, 1, 16'h0312, 1, 0, 4'd0);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_bundle", {6'd0, dut_bundle}, {6'd0, 3'd0, 1'b0, 1'b0, 2'd0, 4'd3, 4'd1, 4'd2, 4'd0, 3'b111});
    check("t1_busy3", {31'd0, busy[3]}, 32'd1);

    // 2: SUB r4,r3,r5 stalls on r3 until writeback
    step(0, 1, 16'h1435, 1, 0, 4'd0);
    step(0, 1, 16'h1435, 1, 1, 4'd3);
    check("t2_busy3_clr", {31'd0, busy[3]}, 32'd0);
    step(0, 1, 16'h1435, 1, 0, 4'd0);
    check("t2_sub", {31'd0, out_sub}, 32'd1);

    // 3: shift amount field is not a register read
    step(0, 1, 16'h0500, 1, 0, 4'd0);
    step(0, 1, 16'h4225, 1, 0, 4'd0);
    check("t3_imm", {28'd0, out_imm}, 32'd5);
    check("t3_rt", {28'd0, out_rt}, 32'd0);
    check("t3_flag", {29'd0, out_flag_wr}, 32'd1);

    // 4: back-pressure for 3 cycles, then release issues the next word
    for (int i = 0; i < 3; i++) step(0, 1, 16'h2678, 0, 0, 4'd0);
    step(0, 1, 16'h2678, 1, 0, 4'd0);
    check("t4_rd", {28'd0, out_rd}, 32'd6);

    // 5: illegal opcodes
    step(0, 1, 16'h8123, 1, 0, 4'd0);
    check("t5_ill", {31'd0, ill_op}, 32'd1);
    check("t5_valid", {31'd0, out_valid}, 32'd0);
    step(0, 1, 16'h7123, 1, 0, 4'd0);
    step(0, 0, 16'h0, 1, 0, 4'd0);

    // 6: reset mid-operation
    step(1, 0, 16'h0, 1, 0, 4'd0);
    for (int r = 4; r < 8; r++) step(0, 1, {4'h0, 4'(r), 8'h00}, 1, 0, 4'd0);
    check("t6_busy", {16'd0, busy}, 32'h00F0);
    step(1, 1, 16'h0900, 0, 1, 4'd4);
    check("t6_busy_rst", {16'd0, busy}, 32'd0);
    check("t6_valid_rst", {31'd0, out_valid}, 32'd0);
    rst = 0; in_valid = 1; in_instr = 16'h0400; out_ready = 0; #1;
    check("t6_ready", {31'd0, in_ready}, 32'd1);
    #1;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           {op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15))},
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
